// File: rtl/gost_pkg.sv
// GOST 28147-89 / Magma shared definitions.
// Holds the id-tc26-gost-28147-param-Z S-box set, the cipher geometry
// constants, the decoder FSM state type and the decrypt key-schedule index
// function. The encoder pipeline uses the same table and constants.
package gost_pkg;

    localparam int GOST_ROUNDS = 32;
    localparam int GOST_HALF_W = 32;
    localparam int GOST_KEY_W  = 256;

    // GOST_SBOX[j][n] = pi_j(n). Each 64-bit row lists pi_j(15) down to pi_j(0),
    // and row 0 (the least significant row) serves nibble 0 of the round input.
    localparam logic [7:0][15:0][3:0] GOST_SBOX = {
        64'h2BC96AF43850DE71,  // pi_7
        64'h73AD0B4FC19652E8,  // pi_6
        64'h0E34187BAC296FD5,  // pi_5
        64'hC24BE390D618A5F7,  // pi_4
        64'hB9E35A076F4D128C,  // pi_3
        64'h069C471EDAF2853B,  // pi_2
        64'hF0DB74E1C5A93286,  // pi_1
        64'h1F307D8E9B5A264C   // pi_0
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dec_state_t;

    // Decrypt order: K0..K7 once, then K7..K0 three times.
    // For cnt >= 8, 7 - cnt%8 is just the inverted low three bits.
    function automatic logic [2:0] gost_dec_key_idx(input logic [4:0] cnt);
        return (cnt[4:3] == 2'b00) ? cnt[2:0] : ~cnt[2:0];
    endfunction

endpackage

// File: rtl/gost_round_f.sv
// GOST round function f(x,k) = rol11(S(x + k mod 2^32)).
// Purely combinational; shared by the encoder stages and the iterative decoder.
// Ports:
//   x : 32-bit half-block input
//   k : 32-bit round key
//   f : 32-bit round function result
module gost_round_f
    import gost_pkg::*;
(
    input  logic [GOST_HALF_W-1:0] x,
    input  logic [GOST_HALF_W-1:0] k,
    output logic [GOST_HALF_W-1:0] f
);

    logic [GOST_HALF_W-1:0] sum;
    logic [GOST_HALF_W-1:0] sub;

    assign sum = x + k;

    always_comb begin
        sub = '0;
        for (int j = 0; j < 8; j++) begin
            sub[4*j +: 4] = GOST_SBOX[j][sum[4*j +: 4]];
        end
    end

    // Rotate left by 11.
    assign f = {sub[GOST_HALF_W-12:0], sub[GOST_HALF_W-1:GOST_HALF_W-11]};

endmodule

// File: rtl/gost_decoder.sv
// Iterative GOST 28147-89 / Magma block decoder.
// Accepts one ciphertext block plus key, runs 32 Feistel rounds through one
// shared round unit (one round per clock) and presents the plaintext until the
// downstream handshake. One block per 34 clocks.
// Ports:
//   clk_i         clock, rising edge
//   ss_aresetn_i  asynchronous active-low reset
//   ss_tvalid_i   ciphertext valid
//   ss_tdata_i    ciphertext {a1, a0}
//   key_i         256-bit key, K_i = key_i[32*i +: 32]; sampled at acceptance
//   ss_tready_o   decoder idle and able to accept
//   sm_aresetn_o  reset forwarded downstream, released one clock late
//   sm_tvalid_o   plaintext valid
//   sm_tdata_o    plaintext {L, R}
//   sm_tready_i   downstream ready
module gost_decoder
    import gost_pkg::*;
#(
    parameter int TDATA_WIDTH = 64,
    parameter int KEY_WIDTH   = 256,
    parameter int K_WIDTH     = 32,
    parameter int R_WIDTH     = 32
) (
    input  logic                   clk_i,
    input  logic                   ss_aresetn_i,
    input  logic                   ss_tvalid_i,
    input  logic [TDATA_WIDTH-1:0] ss_tdata_i,
    input  logic [KEY_WIDTH-1:0]   key_i,
    output logic                   ss_tready_o,
    output logic                   sm_aresetn_o,
    output logic                   sm_tvalid_o,
    output logic [TDATA_WIDTH-1:0] sm_tdata_o,
    input  logic                   sm_tready_i
);

    dec_state_t           state;
    dec_state_t           state_next;
    logic [4:0]           cnt;
    logic [R_WIDTH-1:0]   l_reg;
    logic [R_WIDTH-1:0]   r_reg;
    logic [KEY_WIDTH-1:0] key_reg;
    logic [2:0]           kidx;
    logic [K_WIDTH-1:0]   kd;
    logic [R_WIDTH-1:0]   f_out;
    logic                 last_round;
    logic                 arst_q;

    assign last_round = (cnt == 5'(GOST_ROUNDS - 1));
    assign kidx       = gost_dec_key_idx(cnt);
    assign kd         = key_reg[kidx*K_WIDTH +: K_WIDTH];

    gost_round_f u_round (
        .x (r_reg),
        .k (kd),
        .f (f_out)
    );

    always_ff @(posedge clk_i or negedge ss_aresetn_i) begin
        if (!ss_aresetn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (ss_tvalid_i) state_next = ST_RUN;
            ST_RUN:  if (last_round)  state_next = ST_DONE;
            ST_DONE: if (sm_tready_i) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Round 31 skips the half swap so the output is {L, R} directly.
    always_ff @(posedge clk_i or negedge ss_aresetn_i) begin
        if (!ss_aresetn_i) begin
            cnt     <= '0;
            l_reg   <= '0;
            r_reg   <= '0;
            key_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ss_tvalid_i) begin
                        l_reg   <= ss_tdata_i[TDATA_WIDTH-1 -: R_WIDTH];
                        r_reg   <= ss_tdata_i[R_WIDTH-1:0];
                        key_reg <= key_i;
                        cnt     <= '0;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 5'd1;
                    if (last_round) begin
                        l_reg <= l_reg ^ f_out;
                    end else begin
                        l_reg <= r_reg;
                        r_reg <= l_reg ^ f_out;
                    end
                end
                default: ;
            endcase
        end
    end

    // Downstream reset asserts with ours and releases one clock later.
    always_ff @(posedge clk_i or negedge ss_aresetn_i) begin
        if (!ss_aresetn_i) begin
            arst_q <= 1'b0;
        end else begin
            arst_q <= 1'b1;
        end
    end

    // IDLE is also the reset state, so ready is masked while reset is held.
    assign ss_tready_o  = ss_aresetn_i && (state == ST_IDLE);
    assign sm_tvalid_o  = (state == ST_DONE);
    assign sm_tdata_o   = {l_reg, r_reg};
    assign sm_aresetn_o = arst_q;

endmodule

// File: tb/tb_gost_decoder.sv
module tb_gost_decoder;

    localparam logic [255:0] K_STD = 256'hfcfdfeff_f8f9fafb_f4f5f6f7_f0f1f2f3_33221100_77665544_bbaa9988_ffeeddcc;
    localparam logic [255:0] K_RT  = 256'h96696996_69969669_69969669_96696996_69969669_96696996_96696996_69969669;
    localparam logic [63:0]  C_STD = 64'h4ee901e5c2d8ca3d;
    localparam logic [63:0]  P_STD = 64'hfedcba9876543210;

    logic         clk = 1'b0;
    logic         ss_aresetn_i;
    logic         ss_tvalid_i;
    logic [63:0]  ss_tdata_i;
    logic [255:0] key_i;
    logic         ss_tready_o;
    logic         sm_aresetn_o;
    logic         sm_tvalid_o;
    logic [63:0]  sm_tdata_o;
    logic         sm_tready_i;

    always #5 clk = ~clk;

    gost_decoder dut (
        .clk_i        (clk),
        .ss_aresetn_i (ss_aresetn_i),
        .ss_tvalid_i  (ss_tvalid_i),
        .ss_tdata_i   (ss_tdata_i),
        .key_i        (key_i),
        .ss_tready_o  (ss_tready_o),
        .sm_aresetn_o (sm_aresetn_o),
        .sm_tvalid_o  (sm_tvalid_o),
        .sm_tdata_o   (sm_tdata_o),
        .sm_tready_i  (sm_tready_i)
    );

    // S-box set param-Z, pi_j(0..15) in natural order.
    int SB [8][16] = '{
        '{12, 4, 6, 2,10, 5,11, 9,14, 8,13, 7, 0, 3,15, 1},
        '{ 6, 8, 2, 3, 9,10, 5,12, 1,14, 4, 7,11,13, 0,15},
        '{11, 3, 5, 8, 2,15,10,13,14, 1, 7, 4,12, 9, 6, 0},
        '{12, 8, 2, 1,13, 4,15, 6, 7, 0,10, 5, 3,14, 9,11},
        '{ 7,15, 5,10, 8, 1, 6,13, 0, 9, 3,14,11, 4, 2,12},
        '{ 5,13,15, 6, 9, 2,12,10,11, 7, 8, 1, 4, 3,14, 0},
        '{ 8,14, 2, 5, 6, 9, 1,12,15, 4,11, 0,13,10, 3, 7},
        '{ 1, 7,14,13, 0, 5, 8, 3, 4,15,10, 6, 9,12,11, 2}
    };

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_t(input logic [31:0] a);
        logic [31:0] t;
        t = '0;
        for (int j = 0; j < 8; j++) t[4*j +: 4] = 4'(SB[j][a[4*j +: 4]]);
        return t;
    endfunction

    function automatic logic [31:0] ref_g(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] s;
        s = ref_t(a + k);
        return (s << 11) | (s >> 21);
    endfunction

    // enc: 1 -> K order 0..7 x3 then 7..0;  dec: 0..7 then 7..0 x3
    function automatic logic [63:0] ref_cipher(input logic [63:0] blk, input logic [255:0] key, input bit enc);
        logic [31:0] a1, a0, tmp;
        int idx;
        a1 = blk[63:32];
        a0 = blk[31:0];
        for (int i = 0; i < 32; i++) begin
            if (enc) idx = (i < 24) ? (i % 8) : (7 - i % 8);
            else     idx = (i < 8)  ? i       : (7 - i % 8);
            if (i < 31) begin
                tmp = a0;
                a0  = a1 ^ ref_g(a0, key[32*idx +: 32]);
                a1  = tmp;
            end else begin
                a1 = a1 ^ ref_g(a0, key[32*idx +: 32]);
            end
        end
        return {a1, a0};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- cycle monitor / model ----------------
    logic [63:0]  orig_q [$];
    int           cyc = 0;
    bit           p_rst = 1'b1;
    logic         p_vld = 1'b0, p_rdy = 1'b0;
    logic [63:0]  p_data = '0, p_out = '0;
    logic [255:0] p_key = '0;
    bit           m_valid = 1'b0;
    int           m_pend = -1;
    logic [63:0]  m_data = '0, m_next = '0;
    logic         exp_arst;
    int           accepts = 0, handshakes = 0, dropped = 0;
    bit           cont_mode = 1'b0;
    int           cont_accs = 0, last_acc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!ss_aresetn_i) begin
            chk("rst_tready", {63'd0, ss_tready_o}, 64'd0);
            chk("rst_tvalid", {63'd0, sm_tvalid_o}, 64'd0);
            chk("rst_tdata", sm_tdata_o, 64'd0);
            chk("rst_aresetn", {63'd0, sm_aresetn_o}, 64'd0);
            if (m_valid || m_pend >= 0) dropped++;
            m_valid = 1'b0;
            m_pend  = -1;
            p_rst   = 1'b1;
            p_vld   = 1'b0;
            p_rdy   = 1'b0;
        end else begin
            if (p_rst) begin
                exp_arst = 1'b0;
            end else begin
                exp_arst = 1'b1;
                if (m_valid) begin
                    if (p_rdy) begin
                        m_valid = 1'b0;
                        handshakes++;
                        if (orig_q.size() == 0) chk("unexpected_output", p_out, 64'd0 ^ ~p_out);
                        else chk("in_order_plain", p_out, orig_q.pop_front());
                    end
                end else if (m_pend > 0) begin
                    m_pend--;
                    if (m_pend == 0) begin
                        m_valid = 1'b1;
                        m_data  = m_next;
                        m_pend  = -1;
                    end
                end else if (p_vld) begin
                    m_pend = 32;
                    m_next = ref_cipher(p_data, p_key, 1'b0);
                    accepts++;
                    if (cont_mode) begin
                        if (cont_accs > 0) chk("accept_interval", 64'(cyc - last_acc), 64'd34);
                        last_acc = cyc;
                        cont_accs++;
                    end
                end
            end
            if (!cont_mode) cont_accs = 0;
            chk("tready", {63'd0, ss_tready_o}, {63'd0, (!m_valid && m_pend < 0)});
            chk("tvalid", {63'd0, sm_tvalid_o}, {63'd0, m_valid});
            chk("aresetn_out", {63'd0, sm_aresetn_o}, {63'd0, exp_arst});
            chk("ready_valid_excl", {63'd0, ss_tready_o & sm_tvalid_o}, 64'd0);
            if (m_valid) chk("tdata", sm_tdata_o, m_data);
            p_rst  = 1'b0;
            p_vld  = ss_tvalid_i;
            p_rdy  = sm_tready_i;
            p_data = ss_tdata_i;
            p_key  = key_i;
            p_out  = sm_tdata_o;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [63:0] ct, input logic [255:0] k, input logic [63:0] pt, input bit hold);
        bit ok, rdy;
        ss_tdata_i  = ct;
        key_i       = k;
        ss_tvalid_i = 1'b1;
        orig_q.push_back(pt);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            rdy = ss_tready_o;
            @(posedge clk);
            #1;
            ok = rdy;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: block %h never accepted", ct);
        end
        if (!hold) ss_tvalid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (sm_tvalid_o) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_valid_timeout: sm_tvalid_o never rose");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           hs0;
        logic [63:0]  pt, hold_v;
        logic [255:0] k;

        ss_aresetn_i = 1'b1;
        ss_tvalid_i  = 1'b0;
        ss_tdata_i   = '0;
        key_i        = '0;
        sm_tready_i  = 1'b1;
        #1 ss_aresetn_i = 1'b0;

        // Literal pins on the model itself
        chk("pin_sbox_t", {32'd0, ref_t(32'hfdb97531)}, 64'h2a196f34);
        chk("pin_round_g", {32'd0, ref_g(32'hfedcba98, 32'h87654321)}, 64'hfdcbc20c);
        chk("pin_enc", ref_cipher(P_STD, K_STD, 1'b1), C_STD);
        chk("pin_dec", ref_cipher(C_STD, K_STD, 1'b0), P_STD);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tready", {63'd0, ss_tready_o}, 64'd0);
        chk("reset_tvalid", {63'd0, sm_tvalid_o}, 64'd0);
        chk("reset_tdata", sm_tdata_o, 64'd0);
        chk("reset_aresetn", {63'd0, sm_aresetn_o}, 64'd0);
        ss_aresetn_i = 1'b1;
        @(negedge clk);
        chk("release_tready", {63'd0, ss_tready_o}, 64'd1);
        @(posedge clk);
        #1;
        chk("release_aresetn", {63'd0, sm_aresetn_o}, 64'd1);

        // Standard vector and latency
        send(C_STD, K_STD, P_STD, 1'b0);
        wait_valid(lat);
        chk("std_latency", 64'(lat), 64'd32);
        chk("std_plain", sm_tdata_o, P_STD);
        @(posedge clk);
        #1;
        chk("std_after_hs_valid", {63'd0, sm_tvalid_o}, 64'd0);
        chk("std_after_hs_ready", {63'd0, ss_tready_o}, 64'd1);

        // Backpressure
        repeat (2) @(posedge clk);
        #1;
        sm_tready_i = 1'b0;
        pt = {$urandom, $urandom};
        k  = rand256();
        hs0 = handshakes;
        send(ref_cipher(pt, k, 1'b1), k, pt, 1'b0);
        wait_valid(lat);
        hold_v = sm_tdata_o;
        chk("bp_plain", hold_v, pt);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp_hold_data", sm_tdata_o, hold_v);
            chk("bp_hold_valid", {63'd0, sm_tvalid_o}, 64'd1);
            chk("bp_ready_low", {63'd0, ss_tready_o}, 64'd0);
        end
        sm_tready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_ready", {63'd0, ss_tready_o}, 64'd1);
        chk("bp_idle_valid", {63'd0, sm_tvalid_o}, 64'd0);
        @(negedge clk);
        #1;
        chk("bp_one_handshake", 64'(handshakes - hs0), 64'd1);

        // Reset in the middle of a block (cnt = 15)
        @(posedge clk);
        #1;
        send(C_STD, K_STD, P_STD, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        ss_aresetn_i = 1'b0;
        #1;
        chk("midrst_tready", {63'd0, ss_tready_o}, 64'd0);
        chk("midrst_tvalid", {63'd0, sm_tvalid_o}, 64'd0);
        chk("midrst_tdata", sm_tdata_o, 64'd0);
        chk("midrst_aresetn", {63'd0, sm_aresetn_o}, 64'd0);
        void'(orig_q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        ss_aresetn_i = 1'b1;
        @(negedge clk);
        chk("midrst_release_tready", {63'd0, ss_tready_o}, 64'd1);
        @(posedge clk);
        #1;
        send(C_STD, K_STD, P_STD, 1'b0);
        wait_valid(lat);
        chk("midrst_std_latency", 64'(lat), 64'd32);
        chk("midrst_std_plain", sm_tdata_o, P_STD);
        @(posedge clk);
        #1;

        // Inputs scrambled while the block is in flight
        pt = {$urandom, $urandom};
        k  = rand256();
        send(ref_cipher(pt, k, 1'b1), k, pt, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (sm_tvalid_o) chk("scramble_plain", sm_tdata_o, pt);
            @(posedge clk);
            #1;
            ss_tdata_i = {$urandom, $urandom};
            key_i      = rand256();
        end

        // Round trip, valid and ready held high: 100 blocks back to back
        cont_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pt = {$urandom, $urandom};
            send(ref_cipher(pt, K_RT, 1'b1), K_RT, pt, (i < 99));
        end
        wait_valid(lat);
        @(posedge clk);
        #1;
        cont_mode = 1'b0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        chk("all_blocks_delivered", 64'(orig_q.size()), 64'd0);
        chk("no_lost_or_dup", 64'(handshakes + dropped), 64'(accepts));
        chk("one_dropped_by_reset", 64'(dropped), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
